// File: rtl/wb_slave_mem_responder.sv
// wb_slave_mem_responder: Wishbone B3 classic slave buffer RAM answering the
// ethmac DMA master. Word-addressed RAM with byte-lane writes, fixed wait
// states and ERR termination on misaligned or out-of-range accesses.
// Optional feature macro: WB_SLV_RAND_WAIT_EN (LFSR-randomised wait count).
module wb_slave_mem_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h0000_1000,
  parameter int                    WAIT_STATES = 1,
  parameter logic [15:0]           LFSR_SEED   = 16'hACE1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [7:0]              err_cnt_o
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] END_ADDR = BASE_ADDR + ADDR_WIDTH'(4 * MEM_DEPTH);

  // The wait counter is 4 bits wide and an all-zero LFSR would lock up.
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("WAIT_STATES must lie in 0..15");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_GAP} state_t;

  state_t                  state_q;
  logic [3:0]              waitcnt_q;
  logic                    ack_q, err_q;
  logic [DATA_WIDTH-1:0]   rdat_q;
  logic [7:0]              err_cnt_q;

  logic                    req_hit_q, req_we_q;
  logic [IDX_W-1:0]        req_idx_q;
  logic [SEL_W-1:0]        req_sel_q;
  logic [DATA_WIDTH-1:0]   req_dat_q;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic                    hit_d;
  logic [IDX_W-1:0]        idx_d;
  logic [3:0]              wait_load_d;
  logic                    start_d;

  assign hit_d   = (wb_adr_i >= BASE_ADDR) && (wb_adr_i < END_ADDR) && (wb_adr_i[1:0] == 2'b00);
  assign idx_d   = IDX_W'((wb_adr_i - BASE_ADDR) >> 2);
  assign start_d = (state_q == S_IDLE) && wb_cyc_i && wb_stb_i;

`ifdef WB_SLV_RAND_WAIT_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb_d;

  assign lfsr_fb_d   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign wait_load_d = 4'(32'(lfsr_q[3:0]) % (WAIT_STATES + 1));

  // Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11+1) picking the wait count.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= {lfsr_q[14:0], lfsr_fb_d};
  end
`else
  assign wait_load_d = 4'(WAIT_STATES);
`endif

  // Capture the request on acceptance; held stable until the response cycle.
  always_ff @(posedge wb_clk_i) begin
    if (start_d) begin
      req_hit_q <= hit_d;
      req_we_q  <= wb_we_i;
      req_idx_q <= idx_d;
      req_sel_q <= wb_sel_i;
      req_dat_q <= wb_dat_i;
    end
  end

  // Commit selected byte lanes of a write hit on the response edge.
  always_ff @(posedge wb_clk_i) begin
    if (state_q == S_RESP && req_hit_q && req_we_q) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (req_sel_q[b]) mem_q[req_idx_q][8*b +: 8] <= req_dat_q[8*b +: 8];
      end
    end
  end

  // Transfer FSM with registered ACK/ERR/read-data and error counter.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      waitcnt_q <= 4'd0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdat_q    <= '0;
      err_cnt_q <= 8'd0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            waitcnt_q <= wait_load_d;
            state_q   <= (wait_load_d != 4'd0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (!wb_cyc_i) begin
            waitcnt_q <= 4'd0;
            state_q   <= S_IDLE;
          end else begin
            waitcnt_q <= waitcnt_q - 4'd1;
            if (waitcnt_q <= 4'd1) state_q <= S_RESP;
          end
        end
        S_RESP: begin
          ack_q <= req_hit_q;
          err_q <= ~req_hit_q;
          if (req_hit_q && !req_we_q) rdat_q <= mem_q[req_idx_q];
          if (!req_hit_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          state_q <= S_GAP;
        end
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wb_dat_o  = rdat_q;
  assign err_cnt_o = err_cnt_q;

endmodule
